// File: rtl/sccb_writer_if.sv
// SCCB writer bus: request handshake plus SIOC/SIOD pins.
// With SCCB_ACK_CHECK_EN the bus also carries siod_in and nack.
`timescale 1ns/1ps
interface sccb_writer_if;
    logic       start;
    logic [7:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       ready;
    logic       done;
    logic       sioc;
    logic       siod_out;
    logic       siod_oe;
`ifdef SCCB_ACK_CHECK_EN
    logic       siod_in;
    logic       nack;

    modport master (
        output start, dev_addr, reg_addr, reg_data, siod_in,
        input  ready, done, sioc, siod_out, siod_oe, nack
    );
    modport slave (
        input  start, dev_addr, reg_addr, reg_data, siod_in,
        output ready, done, sioc, siod_out, siod_oe, nack
    );
`else
    modport master (
        output start, dev_addr, reg_addr, reg_data,
        input  ready, done, sioc, siod_out, siod_oe
    );
    modport slave (
        input  start, dev_addr, reg_addr, reg_data,
        output ready, done, sioc, siod_out, siod_oe
    );
`endif
endinterface

// File: rtl/sccb_writer.sv
// SCCB 3-phase register writer; one SIOC bit period is four enable ticks.
// Define SCCB_ACK_CHECK_EN to sample siod_in in each 9th bit into a sticky nack.
`timescale 1ns/1ps
module sccb_writer #(
    parameter int unsigned IDLE_TICKS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    sccb_writer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, BITS, STOP, GAP} state_t;

    localparam logic [7:0] GAP_LAST = 8'(IDLE_TICKS - 1);

    state_t      state, state_n;
    logic [1:0]  q, q_n;
    logic [4:0]  bitn, bitn_n;
    logic [23:0] sr, sr_n;
    logic [7:0]  gap_cnt, gap_n;
    logic        fin, fin_n;
    logic        ack_bit;
    logic        sioc_n, siod_n, oe_n;

    assign ack_bit = (bitn == 5'd8) || (bitn == 5'd17) || (bitn == 5'd26);

    always_comb begin
        state_n = state;
        q_n     = q;
        bitn_n  = bitn;
        sr_n    = sr;
        gap_n   = gap_cnt;
        fin_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = START;
                    q_n     = '0;
                    bitn_n  = '0;
                    sr_n    = {bus.dev_addr, bus.reg_addr, bus.reg_data};
                end
            end
            START: begin
                if (enable) begin
                    q_n = q + 2'd1;
                    if (q == 2'd3) state_n = BITS;
                end
            end
            BITS: begin
                if (enable) begin
                    q_n = q + 2'd1;
                    if (q == 2'd3) begin
                        // ack slots do not consume frame bits
                        if (!ack_bit) sr_n = {sr[22:0], 1'b0};
                        if (bitn == 5'd26) state_n = STOP;
                        else bitn_n = bitn + 5'd1;
                    end
                end
            end
            STOP: begin
                if (enable) begin
                    q_n = q + 2'd1;
                    if (q == 2'd3) begin
                        state_n = GAP;
                        gap_n   = '0;
                    end
                end
            end
            GAP: begin
                if (enable) begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n = IDLE;
                        fin_n   = 1'b1;
                    end else begin
                        gap_n = gap_cnt + 8'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        sioc_n = 1'b1;
        siod_n = 1'b1;
        oe_n   = 1'b1;
        case (state)
            START: siod_n = ~q[1];
            BITS: begin
                sioc_n = q[1];
                if (ack_bit) begin
                    siod_n = 1'b0;
                    oe_n   = 1'b0;
                end else begin
                    siod_n = sr[23];
                end
            end
            STOP: begin
                sioc_n = q[1];
                siod_n = (q == 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            q            <= '0;
            bitn         <= '0;
            sr           <= '0;
            gap_cnt      <= '0;
            fin          <= 1'b0;
            bus.ready    <= 1'b1;
            bus.done     <= 1'b0;
            bus.sioc     <= 1'b1;
            bus.siod_out <= 1'b1;
            bus.siod_oe  <= 1'b1;
        end else begin
            state        <= state_n;
            q            <= q_n;
            bitn         <= bitn_n;
            sr           <= sr_n;
            gap_cnt      <= gap_n;
            fin          <= fin_n;
            bus.ready    <= (state_n == IDLE);
            bus.done     <= fin;
            bus.sioc     <= sioc_n;
            bus.siod_out <= siod_n;
            bus.siod_oe  <= oe_n;
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.nack <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            bus.nack <= 1'b0;
        end else if (enable && state == BITS && q == 2'd2 && ack_bit && bus.siod_in) begin
            bus.nack <= 1'b1;
        end
    end
`endif
endmodule

// File: doc/sccb_writer.md
# sccb_writer

Serial camera-control (SCCB) register writer clocked by the enable tick from the clock divider. It accepts one 3-phase write (device ID, register address, data) per handshake and shifts it out on SIOC/SIOD. It is used to load the camera sensor's configuration registers before the pixel path starts. Each SIOC bit period spans four enable ticks, so the SIOC frequency equals the tick rate divided by 4.

## Interface
- IDLE_TICKS, 4: enable ticks of bus-free time held after STOP before the next write can be accepted; allowed range 1-255.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  one-clk tick from the clock divider; this is the quarter-bit rate.
- start  in  1  write request, sampled when ready=1.
- dev_addr  in  8  SCCB device ID byte, write form (LSB 0).
- reg_addr  in  8  sensor register address.
- reg_data  in  8  value to write.
- ready  out  1  high when idle and able to accept a write.
- done  out  1  one-clk pulse when the write has completed, including the gap.
- sioc  out  1  SCCB clock.
- siod_out  out  1  SCCB data value.
- siod_oe  out  1  1 = drive siod_out, 0 = release the line.
- siod_in  in  1  sampled SIOD. Present only with SCCB_ACK_CHECK_EN.
- nack  out  1  sticky "slave did not acknowledge" flag. Present only with SCCB_ACK_CHECK_EN.

## Operation
- States: IDLE, START, BITS, STOP, GAP. A 2-bit quarter counter q runs 0..3 and a 5-bit bit counter runs 0..26.
- IDLE
  - ready=1, sioc=1, siod_out=1, siod_oe=1.
  - start=1 on any clk edge accepts the request, whether or not enable is high.
  - On acceptance: latch the 24-bit frame {dev_addr, reg_addr, reg_data}, go to START with q=0, and drop ready on the next clk.
  - start is ignored outside IDLE.
- q increments only on clk edges where enable=1. The state changes on the tick where q wraps 3→0.
- START
  - q0–q1: sioc=1, siod=1.
  - q2–q3: sioc=1, siod=0.
- BITS: 27 bits, 3 bytes × (8 data bits MSB-first + 1 don't-care bit).
  - q0–q1: sioc=0.
  - q2–q3: sioc=1.
  - siod_out is updated at q0 and held through q3.
  - During each 9th bit: siod_oe=0 and siod_out=0.
- STOP
  - q0–q2: siod=0, with sioc=0,0,1.
  - q3: sioc=1, siod=1.
- GAP: sioc=1, siod=1 for IDLE_TICKS ticks. Then done pulses for 1 clk, ready=1, and the state returns to IDLE.
- sioc, siod_out and siod_oe are registered decodes of (state, q, bit) and are glitch-free.

## Timing
- Reset values: ready=1, done=0, sioc=1, siod_out=1, siod_oe=1, nack=0, state=IDLE.
- Reset asserted mid-transfer aborts the write immediately. Outputs take reset values on the next clk, with no STOP generated.
- Outputs lag the (state, q) change by 1 clk.
- Transaction length is 4 + 108 + 4 + IDLE_TICKS enable ticks after acceptance.
- done is asserted on the clk following the final GAP tick.
- A tick arriving in the same cycle as acceptance does not advance q; the first counted tick is the next one.
- enable stuck high is legal: every clk is then one quarter.
- start held high continuously produces back-to-back writes separated only by the GAP.

## Configuration
- SCCB_ACK_CHECK_EN defined:
  - Adds the siod_in and nack ports.
  - siod_in is sampled on the tick at q2 of each 9th bit; a 1 sets nack.
  - nack is cleared on the next accepted start.
  - The transfer always runs to completion regardless of nack.
- SCCB_ACK_CHECK_EN undefined: the siod_in and nack ports do not exist and there is no sampling logic.

## Test plan
- After reset, with enable every 2 clks: sioc=1, siod_out=1, ready=1, done=0.
- Write dev_addr=0x42, reg_addr=0x12, reg_data=0x80 with IDLE_TICKS=4 and enable every 2 clks:
  - Exactly 27 sioc rising edges.
  - Bits decoded on sioc rise read 0x42,x,0x12,x,0x80,x.
  - done pulses on the clk after the 120th tick following acceptance.
- A start pulse mid-transfer is ignored. start held high produces a second identical frame beginning exactly IDLE_TICKS ticks after STOP.
- Reset asserted at bit 10: the next clk shows sioc=1, siod_out=1, ready=1, and no done pulse.
- enable constantly 1: the frame completes in 120 clks and sioc has period 4 clk.
- With SCCB_ACK_CHECK_EN:
  - siod_in=1 during the 2nd 9th bit sets nack=1 at completion.
  - The next start with siod_in=0 clears nack to 0.
